// File: rtl/dff.sv
// rtl/dff.sv - positive-edge D flip-flop with complementary outputs and synchronous active-low reset
//
// Parameters:
//   WIDTH       - bit width of d, q and qb
//   RESET_VALUE - value loaded into q on a reset edge; qb loads its complement
// Ports (positional order d, clk, q, qb, rst_n):
//   d     in  [WIDTH-1:0]  data, sampled on the rising edge of clk
//   clk   in               clock, rising edge only
//   q     out [WIDTH-1:0]  registered data
//   qb    out [WIDTH-1:0]  bitwise complement of q
//   rst_n in               synchronous active-low reset
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    input  logic             rst_n
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // qb comes from the register, never from d, so q and qb stay exact complements.
    assign q  = data_q;
    assign qb = ~data_q;

endmodule

// File: tb/tb_dff.sv
// tb/tb_dff.sv - self-checking bench for dff
module tb_dff;

    logic       clk;
    logic       rst_n;
    logic       d1;
    logic [7:0] d8;
    logic       qa, qba, qbv, qbbv;
    logic [7:0] qc, qbc;

    int n_vec;
    int n_err;

    // a: WIDTH=1 default reset, b: WIDTH=1 reset to 1, c: WIDTH=8 reset to A5
    dff u_a (.d(d1), .clk(clk), .q(qa), .qb(qba), .rst_n(rst_n));
    dff #(.WIDTH(1), .RESET_VALUE(1'b1)) u_b (.d(d1), .clk(clk), .q(qbv), .qb(qbbv), .rst_n(rst_n));
    dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_c (.d(d8), .clk(clk), .q(qc), .qb(qbc), .rst_n(rst_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       d1;
        logic [7:0] d8;
        logic       ea;
        logic       eb;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic ea, input logic eb, input logic [7:0] ec);
        chk({nm, " a.q"},  {7'd0, qa},   {7'd0, ea});
        chk({nm, " a.qb"}, {7'd0, qba},  {7'd0, ~ea});
        chk({nm, " b.q"},  {7'd0, qbv},  {7'd0, eb});
        chk({nm, " b.qb"}, {7'd0, qbbv}, {7'd0, ~eb});
        chk({nm, " c.q"},  qc,  ec);
        chk({nm, " c.qb"}, qbc, ~ec);
    endtask

    logic       m_a, m_b;
    logic [7:0] m_c;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        d1    = 1'b1;
        d8    = 8'hFF;

        // reset wins over d=1 / d=FF
        @(posedge clk); #1;
        chk_all("reset", 1'b0, 1'b1, 8'hA5);

        tbl[0] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C};
        tbl[1] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF};
        tbl[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A};
        tbl[6] = '{1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 8'h81};

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n;
            d1    = tbl[i].d1;
            d8    = tbl[i].d8;
            @(posedge clk); #1;
            chk_all($sformatf("table%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec);
        end

        // q=1 held; d changes on falling edge and glitches in both phases
        @(negedge clk);
        d1 = 1'b0; d8 = 8'h00;
        #1 chk_all("falling edge hold", 1'b1, 1'b1, 8'h81);
        d1 = 1'b1; d8 = 8'hFF;
        #1 d1 = 1'b0; d8 = 8'h00;
        #1 chk_all("low-phase glitch", 1'b1, 1'b1, 8'h81);
        @(posedge clk); #1;
        chk_all("capture 0", 1'b0, 1'b0, 8'h00);
        d1 = 1'b1; d8 = 8'h77;
        #1 d1 = 1'b0; d8 = 8'h00;
        #1 chk_all("high-phase glitch", 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        d1 = 1'b1; d8 = 8'hC3;
        @(posedge clk); #1;
        chk_all("capture 1", 1'b1, 1'b1, 8'hC3);

        // reset pulse entirely inside the low phase is ignored
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("short reset ignored", 1'b1, 1'b1, 8'hC3);

        // reset held over an edge, then released with d=1
        @(negedge clk);
        d1 = 1'b0; d8 = 8'h11;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_all("reset over edge", 1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1; d1 = 1'b1; d8 = 8'h3C;
        #1 chk_all("release between edges", 1'b0, 1'b1, 8'hA5);
        @(posedge clk); #1;
        chk_all("first edge after release", 1'b1, 1'b1, 8'h3C);

        // random regression against a reference model
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 9) != 0);
            d1    = 1'($urandom);
            d8    = 8'($urandom);
            m_a   = rst_n ? d1 : 1'b0;
            m_b   = rst_n ? d1 : 1'b1;
            m_c   = rst_n ? d8 : 8'hA5;
            @(posedge clk); #1;
            // later input changes must not disturb the captured value
            d1 = ~d1; d8 = ~d8;
            #1 chk_all($sformatf("random%0d", cyc), m_a, m_b, m_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
